// File: rtl/rr_mux_reg.sv
// rr_mux_reg: NUM_IN-channel round-robin (or forced-select) merge of
// valid/ready producers into a single registered output stage.
// Optional feature macro: RR_MUX_XFER_COUNT_EN adds a 16-bit xfer_count
// output counting accepted input transfers since reset.
module rr_mux_reg #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    force_en,
    input  logic [SEL_W-1:0]        force_sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef RR_MUX_XFER_COUNT_EN
    ,
    output logic [15:0]             xfer_count
`endif
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [SEL_W-1:0]   rr_ptr;
    logic               grant_valid;
    logic [SEL_W-1:0]   grant_idx;
    logic [WIDTH-1:0]   grant_data;
    logic               load_en;
    logic               xfer;

    // Output register may take a new word when empty or being drained this cycle
    assign load_en = rst_n & (~out_valid | out_ready);
    assign xfer    = load_en & grant_valid;

    // Arbitration: forced channel only, else first valid scanning from rr_ptr
    always_comb begin
        logic [SEL_W-1:0] idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        if (force_en) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if ((32'(force_sel) == i) && in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(i);
                end
            end
        end else begin
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                idx = SEL_W'((32'(rr_ptr) + k) % NUM_IN);
                if (!grant_valid && in_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx;
                end
            end
        end
    end

    // Data mux for the granted channel
    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register: output stage EMPTY/FULL
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: load keeps/makes FULL, drain without load empties
    always_comb begin
        state_d = state_q;
        if (xfer) begin
            state_d = FULL;
        end else if (out_ready) begin
            state_d = EMPTY;
        end
    end

    // Outputs decoded from state and grant
    always_comb begin
        out_valid = (state_q == FULL);
        in_ready  = '0;
        if (xfer) begin
            in_ready = NUM_IN'(1) << grant_idx;
        end
    end

    // Output data/select register and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= '0;
            out_sel  <= '0;
            rr_ptr   <= '0;
        end else if (xfer) begin
            out_data <= grant_data;
            out_sel  <= grant_idx;
            if (!force_en) begin
                rr_ptr <= SEL_W'((32'(grant_idx) + 32'd1) % NUM_IN);
            end
        end
    end

`ifdef RR_MUX_XFER_COUNT_EN
    // Transfer counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (xfer) begin
            xfer_count <= xfer_count + CNT_W'(1);
        end
    end
`else
    // Counter width kept referenced so the default build carries no dangling constant
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule
